// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared FIFO definitions: default geometry and the pointer code
// conversions used on both sides of the clock-domain crossing.
// Functions work on a 32-bit container; callers zero-extend their pointer
// in and truncate the result back to pointer width.
package fifo_rd_ctrl_pkg;

  localparam int unsigned DEF_ADDR_SIZE   = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  function automatic logic [31:0] bin2grey(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits in the container leave the conversion unaffected.
  function automatic logic [31:0] grey2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int unsigned i = 31; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side FIFO control bus.
//   slave  : the read controller (takes request/write pointer, drives status)
//   master : the read-side user (drives request/threshold/clear)
// Signals: rd_en, wr_ptr_grey, aempty_thresh, underflow_clr (to controller);
//          empty, almost_empty, rd_fill, rd_valid, underflow,
//          rd_addr_grey, rd_addr_bin (from controller).
interface fifo_rd_ctrl_if
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE
);
  logic                 rd_en;
  logic [ADDR_SIZE:0]   wr_ptr_grey;
  logic [ADDR_SIZE:0]   aempty_thresh;
  logic                 underflow_clr;
  logic                 empty;
  logic                 almost_empty;
  logic [ADDR_SIZE:0]   rd_fill;
  logic                 rd_valid;
  logic                 underflow;
  logic [ADDR_SIZE:0]   rd_addr_grey;
  logic [ADDR_SIZE-1:0] rd_addr_bin;

  modport slave (
    input  rd_en, wr_ptr_grey, aempty_thresh, underflow_clr,
    output empty, almost_empty, rd_fill, rd_valid, underflow,
           rd_addr_grey, rd_addr_bin
  );

  modport master (
    output rd_en, wr_ptr_grey, aempty_thresh, underflow_clr,
    input  empty, almost_empty, rd_fill, rd_valid, underflow,
           rd_addr_grey, rd_addr_bin
  );
endinterface

// File: rtl/fifo_rd_ctrl_sync.sv
// ptr_sync: multi-flop synchroniser for a Gray-coded pointer.
//   i_clk   destination clock
//   i_rst_n asynchronous active-low reset (all stages to 0)
//   i_d     pointer from the foreign clock domain
//   o_q     last synchroniser stage
module ptr_sync
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_ADDR_SIZE + 1,
  parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= i_d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO.
//   rd_clk  read-domain clock
//   rd_rst  asynchronous active-low reset
//   bus     fifo_rd_ctrl_if.slave: read request, unsynchronised Gray write
//           pointer, almost-empty threshold, underflow clear in; empty,
//           almost_empty, fill level, read-valid, sticky underflow, Gray
//           read pointer and binary RAM read address out.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_SIZE   = DEF_ADDR_SIZE,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic           rd_clk,
  input  logic           rd_rst,
  fifo_rd_ctrl_if.slave  bus
);

  localparam int unsigned PW = ADDR_SIZE + 1;

  logic [PW-1:0] w_wq;
  logic [PW-1:0] w_wr_bin;
  logic [PW-1:0] w_bin_next;
  logic [PW-1:0] w_grey_next;
  logic [PW-1:0] w_fill_next;
  logic          w_accept;

  logic [PW-1:0] r_bin;
  logic [PW-1:0] r_grey;
  logic [PW-1:0] r_fill;
  logic          r_empty;
  logic          r_aempty;
  logic          r_valid;
  logic          r_underflow;

  ptr_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .i_clk   (rd_clk),
    .i_rst_n (rd_rst),
    .i_d     (bus.wr_ptr_grey),
    .o_q     (w_wq)
  );

  always_comb begin
    w_accept    = bus.rd_en & ~r_empty;
    w_bin_next  = r_bin + {{ADDR_SIZE{1'b0}}, w_accept};
    w_grey_next = PW'(bin2grey(32'(w_bin_next)));
    w_wr_bin    = PW'(grey2bin(32'(w_wq)));
    w_fill_next = w_wr_bin - w_bin_next;
  end

  // Status is computed from the post-increment pointer so that the read
  // which drains the FIFO raises empty on the same edge it advances.
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      r_bin       <= '0;
      r_grey      <= '0;
      r_fill      <= '0;
      r_empty     <= 1'b1;
      r_aempty    <= 1'b1;
      r_valid     <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_bin       <= w_bin_next;
      r_grey      <= w_grey_next;
      r_fill      <= w_fill_next;
      r_empty     <= (w_grey_next == w_wq);
      r_aempty    <= (w_fill_next <= bus.aempty_thresh);
      r_valid     <= w_accept;
      // A fresh underflow takes priority over a clear on the same edge.
      r_underflow <= (bus.rd_en & r_empty) | (r_underflow & ~bus.underflow_clr);
    end
  end

  assign bus.empty        = r_empty;
  assign bus.almost_empty = r_aempty;
  assign bus.rd_fill      = r_fill;
  assign bus.rd_valid     = r_valid;
  assign bus.underflow    = r_underflow;
  assign bus.rd_addr_grey = r_grey;
  assign bus.rd_addr_bin  = r_bin[ADDR_SIZE-1:0];

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;

  localparam int unsigned AS = 4;

  localparam int unsigned S_EMPTY  = 0;
  localparam int unsigned S_AEMPTY = 1;
  localparam int unsigned S_FILL   = 2;
  localparam int unsigned S_VALID  = 3;
  localparam int unsigned S_UFLOW  = 4;
  localparam int unsigned S_GREY   = 5;
  localparam int unsigned S_BIN    = 6;

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [31:0] val;
  } exp_t;

  logic rd_clk = 1'b0;
  logic rd_rst = 1'b1;
  int   n_vec  = 0;
  int   n_fail = 0;
  exp_t sb [$];

  fifo_rd_ctrl_if #(.ADDR_SIZE(AS)) bus ();

  fifo_rd_ctrl #(
    .ADDR_SIZE   (AS),
    .SYNC_STAGES (2)
  ) dut (
    .rd_clk (rd_clk),
    .rd_rst (rd_rst),
    .bus    (bus)
  );

  always #5 rd_clk = ~rd_clk;

  function automatic logic [31:0] observe(input int unsigned sel);
    case (sel)
      S_EMPTY:  return 32'(bus.empty);
      S_AEMPTY: return 32'(bus.almost_empty);
      S_FILL:   return 32'(bus.rd_fill);
      S_VALID:  return 32'(bus.rd_valid);
      S_UFLOW:  return 32'(bus.underflow);
      S_GREY:   return 32'(bus.rd_addr_grey);
      S_BIN:    return 32'(bus.rd_addr_bin);
      default:  return 'x;
    endcase
  endfunction

  task automatic push(input string tag, input int unsigned sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      n_vec++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge rd_clk);
      #1;
    end
  endtask

  task automatic push_reset_vals(input string tag);
    push({tag, "_empty"},  S_EMPTY,  1);
    push({tag, "_aempty"}, S_AEMPTY, 1);
    push({tag, "_fill"},   S_FILL,   0);
    push({tag, "_valid"},  S_VALID,  0);
    push({tag, "_uflow"},  S_UFLOW,  0);
    push({tag, "_grey"},   S_GREY,   0);
    push({tag, "_bin"},    S_BIN,    0);
  endtask

  task automatic pulse_reset();
    rd_rst = 1'b0;
    #1;
    rd_rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.rd_en         = 1'b0;
    bus.wr_ptr_grey   = '0;
    bus.aempty_thresh = '0;
    bus.underflow_clr = 1'b0;

    // Reset without any clock edge
    #2 rd_rst = 1'b0;
    #1;
    push_reset_vals("rst");
    check();

    // Fill: write pointer 3 shows up on the third edge only
    rd_rst = 1'b1;
    bus.wr_ptr_grey = 5'b00010;
    tick(1);
    push("fill_e1_empty", S_EMPTY, 1); push("fill_e1_fill", S_FILL, 0); check();
    tick(1);
    push("fill_e2_empty", S_EMPTY, 1); push("fill_e2_fill", S_FILL, 0); check();
    tick(1);
    push("fill_e3_empty", S_EMPTY, 0); push("fill_e3_fill", S_FILL, 3);
    push("fill_e3_aempty", S_AEMPTY, 0); check();

    // Drain and underflow
    bus.rd_en = 1'b1;
    tick(1);
    push("dr1_bin", S_BIN, 1); push("dr1_valid", S_VALID, 1);
    push("dr1_fill", S_FILL, 2); push("dr1_empty", S_EMPTY, 0); check();
    tick(1);
    push("dr2_bin", S_BIN, 2); push("dr2_valid", S_VALID, 1);
    push("dr2_fill", S_FILL, 1); push("dr2_empty", S_EMPTY, 0); check();
    tick(1);
    push("dr3_bin", S_BIN, 3); push("dr3_valid", S_VALID, 1);
    push("dr3_empty", S_EMPTY, 1); push("dr3_fill", S_FILL, 0);
    push("dr3_uflow", S_UFLOW, 0); check();
    tick(1);
    push("dr4_bin", S_BIN, 3); push("dr4_valid", S_VALID, 0);
    push("dr4_uflow", S_UFLOW, 1); push("dr4_grey", S_GREY, 5'b00010); check();
    bus.underflow_clr = 1'b1;
    tick(1);
    push("clr_with_rd_uflow", S_UFLOW, 1); check();
    bus.rd_en = 1'b0;
    tick(1);
    push("clr_uflow", S_UFLOW, 0); check();
    bus.underflow_clr = 1'b0;

    // Wrap: 16 entries, 16 reads
    pulse_reset();
    bus.wr_ptr_grey = 5'b11000;
    tick(3);
    push("wrap_full_fill", S_FILL, 16); push("wrap_full_empty", S_EMPTY, 0); check();
    bus.rd_en = 1'b1;
    tick(1);
    push("wrap_r1_grey", S_GREY, 5'b00001); push("wrap_r1_fill", S_FILL, 15); check();
    tick(7);
    push("wrap_r8_bin", S_BIN, 8); push("wrap_r8_fill", S_FILL, 8); check();
    tick(8);
    push("wrap_r16_grey", S_GREY, 5'b11000); push("wrap_r16_bin", S_BIN, 0);
    push("wrap_r16_empty", S_EMPTY, 1); push("wrap_r16_fill", S_FILL, 0); check();
    bus.rd_en = 1'b0;

    // Almost-empty threshold 2, fill 5
    pulse_reset();
    bus.aempty_thresh = 5'd2;
    bus.wr_ptr_grey   = 5'b00111;
    tick(3);
    push("ae_f5_fill", S_FILL, 5); push("ae_f5_ae", S_AEMPTY, 0); check();
    bus.rd_en = 1'b1;
    tick(1);
    push("ae_f4_fill", S_FILL, 4); push("ae_f4_ae", S_AEMPTY, 0); check();
    tick(1);
    push("ae_f3_fill", S_FILL, 3); push("ae_f3_ae", S_AEMPTY, 0); check();
    tick(1);
    push("ae_f2_fill", S_FILL, 2); push("ae_f2_ae", S_AEMPTY, 1); check();
    bus.rd_en = 1'b0;

    // Mid-operation reset at fill 7
    pulse_reset();
    bus.aempty_thresh = '0;
    bus.wr_ptr_grey   = 5'b00100;
    tick(3);
    push("mr_fill7", S_FILL, 7); push("mr_empty0", S_EMPTY, 0); check();
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    push("mr_rd_fill", S_FILL, 6); push("mr_rd_valid", S_VALID, 1); check();
    rd_rst = 1'b0;
    #1;
    push_reset_vals("mr_async");
    check();
    rd_rst = 1'b1;
    tick(1);
    push("mr_e1_empty", S_EMPTY, 1); check();
    tick(1);
    push("mr_e2_empty", S_EMPTY, 1); check();
    tick(1);
    push("mr_e3_empty", S_EMPTY, 0); push("mr_e3_fill", S_FILL, 7); check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter ADDR_SIZE, default 4; FIFO depth is 2^ADDR_SIZE and pointers are ADDR_SIZE+1 bits.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2; sets the flop count of the write-pointer synchroniser.
REQ-003 rd_clk  in  1  read-domain clock; the only clock in the block.
REQ-004 rd_rst  in  1  reset; asynchronous, active-low.
REQ-005 rd_en  in  1  read request.
REQ-006 wr_ptr_grey  in  ADDR_SIZE+1  write pointer, Gray-coded, launched from the write clock domain (unsynchronised).
REQ-007 aempty_thresh  in  ADDR_SIZE+1  almost-empty threshold, quasi-static.
REQ-008 underflow_clr  in  1  clears the sticky underflow flag.
REQ-009 empty  out  1  FIFO empty, registered.
REQ-010 almost_empty  out  1  fill at or below threshold, registered.
REQ-011 rd_fill  out  ADDR_SIZE+1  read-side occupancy, registered, range 0..2^ADDR_SIZE.
REQ-012 rd_valid  out  1  a read was accepted on the previous edge; aligns with synchronous RAM data.
REQ-013 underflow  out  1  sticky flag: a read was attempted while empty.
REQ-014 rd_addr_grey  out  ADDR_SIZE+1  read pointer, Gray-coded, for the write domain.
REQ-015 rd_addr_bin  out  ADDR_SIZE  RAM read address (low bits of the binary pointer).

Function
REQ-016 Synchroniser: wr_ptr_grey passes through SYNC_STAGES rd_clk flops; wq denotes the last stage.
REQ-017 accept = rd_en AND NOT empty; only accept advances the pointer.
REQ-018 bin_next = bin + accept, modulo 2^(ADDR_SIZE+1); grey_next = bin_next XOR (bin_next >> 1); both registered each edge.
REQ-019 Wrap: after 2^ADDR_SIZE accepts, rd_addr_bin returns to 0 and the pointer MSB toggles.
REQ-020 empty registers (grey_next == wq) each edge.
REQ-021 wr_bin = Gray-to-binary(wq), combinational; rd_fill registers (wr_bin - bin_next) modulo 2^(ADDR_SIZE+1).
REQ-022 almost_empty registers (fill_next <= aempty_thresh), where fill_next is the value rd_fill registers.
REQ-023 rd_valid registers accept.
REQ-024 underflow sets on any edge where rd_en AND empty; clears on an edge where underflow_clr=1 and there is no new underflow; set wins when both occur together.
REQ-025 A read attempted while empty leaves the pointers, rd_fill and rd_valid (0) unchanged.
REQ-026 Latency: a write-pointer change clears empty and updates rd_fill at rd_clk edge SYNC_STAGES+1 after it becomes stable.
REQ-027 An accept that empties the FIFO asserts empty on the same edge the pointer advances; there is no extra-read window.

Reset
REQ-028 rd_rst low asynchronously forces: pointers 0, synchroniser flops 0, empty=1, almost_empty=1, rd_fill=0, rd_valid=0, underflow=0.
REQ-029 Reset asserted mid-operation takes effect immediately; the first edge after release evaluates from the reset state.

Structure
REQ-030 The shared FIFO package holds ADDR_SIZE/SYNC_STAGES defaults and the bin-to-Gray and Gray-to-binary functions.
REQ-031 One sub-module, ptr_sync (parametrised width and stage count, asynchronous active-low reset), implements REQ-016; all other logic is in fifo_rd_ctrl.

Verification (ADDR_SIZE=4, SYNC_STAGES=2)
REQ-032 Reset: rd_rst low -> empty=1, almost_empty=1, rd_fill=0, rd_addr_grey=0, rd_addr_bin=0, underflow=0, without a clock.
REQ-033 Fill: wr_ptr_grey set to 5'b00010 (bin 3) before edge 1 -> empty=0 and rd_fill=3 after edge 3, not earlier.
REQ-034 Drain/underflow: from fill 3, rd_en held for 4 edges -> rd_addr_bin 1,2,3,3; empty=1 after the 3rd edge; rd_valid=1,1,1,0; underflow=1 after the 4th edge; a 5th edge with underflow_clr=1 and rd_en=1 -> underflow stays 1; clr with rd_en=0 -> 0.
REQ-035 Wrap: wr_ptr_grey=5'b11000 (bin 16) with 16 reads -> rd_addr_grey=5'b11000, rd_addr_bin=0, empty=1, rd_fill=0.
REQ-036 Almost-empty: aempty_thresh=2, fill 5, continuous reads -> almost_empty rises on the edge rd_fill becomes 2.
REQ-037 Mid-operation reset: rd_rst pulsed low while fill=7 -> all outputs return to REQ-028 values asynchronously; after release, empty clears SYNC_STAGES+1 edges later.
